// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream instruction-memory loader that holds the CPU in reset until the image is written.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = S_CSUM;
  logic [7:0] csum;
`else
  localparam state_t AFTER_LAST = S_DONE;
`endif

  state_t      state, state_next;
  logic [15:0] idx;
  logic [7:0]  hi_byte;
  logic [15:0] len_full;
  logic        last_word;
  logic        accept;
  logic        restart;

  assign len_full  = {word_count[15:8], in_data};
  assign last_word = (idx + 16'd1) == word_count;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        restart = start;
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Oversize lengths are rejected before any data byte is consumed.
        if (in_valid) begin
          if ({1'b0, len_full} > CAP)  state_next = S_ERR;
          else if (len_full == 16'd0)  state_next = AFTER_LAST;
          else                         state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = last_word ? AFTER_LAST : S_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        restart = start;
        if (start) state_next = S_LEN_HI;
      end
      S_ERR: begin
        err     = 1'b1;
        restart = start;
        if (start) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_count <= 16'd0;
      idx        <= 16'd0;
      hi_byte    <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we   <= 1'b0;
      // Release the CPU only once DONE has been held for a full cycle.
      cpu_rst_n <= (state == S_DONE) && (state_next == S_DONE);
      if (restart) begin
        idx <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
        csum <= 8'd0;
`endif
      end
      if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
        case (state)
          S_LEN_HI:  word_count[15:8] <= in_data;
          S_LEN_LO:  word_count[7:0]  <= in_data;
          S_DATA_HI: hi_byte          <= in_data;
          S_DATA_LO: begin
            imem_wdata <= {hi_byte, in_data};
            imem_addr  <= idx[ADDR_W-1:0];
            imem_we    <= 1'b1;
            idx        <= idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader (ADDR_W=4, 16-word capacity).
module tb_instr_loader;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_n = 0;
  int rdy_viol = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];
  int                wr_cyc[$];
  logic [15:0]       shadow[0:15];
  logic [7:0]        q[$];
  logic [15:0]       words[$];

  instr_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      shadow[imem_addr] = imem_wdata;
      wr_n = wr_n + 1;
    end
    if (busy && !in_ready) rdy_viol = rdy_viol + 1;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_n = 0;
    rdy_viol = 0;
  endtask

  // Length field, words high byte first, then the XOR byte when the checksum build is used.
  task automatic build(input logic [15:0] n);
    logic [7:0] x;
    q.delete();
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    foreach (words[i]) begin
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`else
    x = 8'd0;
`endif
  endtask

  task automatic do_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for byte %02h", b);
    end
    @(negedge CLK);
    if (stall > 0) begin
      in_valid = 1'b0;
      repeat (stall) @(negedge CLK);
    end
  endtask

  task automatic run_range(input int lo, input int hi, input int stall);
    for (int i = lo; i < hi; i++) send_byte(q[i], (i == q.size() - 1) ? 0 : stall);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %0h expected 0", in_ready); end
    checks++; if (imem_we !== 1'b0)    begin errors++; $display("FAIL rst_imem_we: got %0h expected 0", imem_we); end
    checks++; if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL rst_cpu_rst_n: got %0h expected 0", cpu_rst_n); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %03b expected 000", {busy, done, err}); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0h expected 0", word_count); end
    RST_N = 1'b1;
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    checks++; if ({in_ready, busy, cpu_rst_n} !== 3'b000) begin errors++; $display("FAIL idle_hold: got %03b expected 000", {in_ready, busy, cpu_rst_n}); end
  endtask

  task automatic test_basic(input int stall, input string tag);
    words = {16'h1234, 16'hABCD, 16'hFFFF};
    build(16'd3);
    clear_log();
    do_start();
    run_range(0, q.size(), stall);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %0h expected 1", tag, done); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL %s_cpu_rst_early: got %0h expected 0", tag, cpu_rst_n); end
    checks++; if (word_count !== 16'd3) begin errors++; $display("FAIL %s_word_count: got %0h expected 3", tag, word_count); end
    @(negedge CLK);
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL %s_cpu_rst_rise: got %0h expected 1", tag, cpu_rst_n); end
    checks++; if (wr_n !== 3) begin errors++; $display("FAIL %s_write_count: got %0d expected 3", tag, wr_n); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL %s_in_ready_busy: got %0d low cycles expected 0", tag, rdy_viol); end
    if (wr_n == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wr_addr[i] !== ADDR_W'(i)) begin errors++; $display("FAIL %s_addr%0d: got %0h expected %0h", tag, i, wr_addr[i], i); end
        checks++; if (wr_data[i] !== words[i]) begin errors++; $display("FAIL %s_data%0d: got %0h expected %0h", tag, i, wr_data[i], words[i]); end
      end
      if (stall == 0) begin
        checks++; if (wr_cyc[1] - wr_cyc[0] !== 2) begin errors++; $display("FAIL %s_spacing01: got %0d expected 2", tag, wr_cyc[1] - wr_cyc[0]); end
        checks++; if (wr_cyc[2] - wr_cyc[1] !== 2) begin errors++; $display("FAIL %s_spacing12: got %0d expected 2", tag, wr_cyc[2] - wr_cyc[1]); end
      end
    end
  endtask

  task automatic test_zero_len();
    words.delete();
    build(16'd0);
    clear_log();
    do_start();
    run_range(0, q.size(), 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0h expected 1", done); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL zero_word_count: got %0h expected 0", word_count); end
    @(negedge CLK);
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_cpu_rst: got %0h expected 1", cpu_rst_n); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wr_n); end
  endtask

  task automatic test_oversize();
    q = {8'h00, 8'h11};
    clear_log();
    do_start();
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL over_cpu_rst_on_start: got %0h expected 0", cpu_rst_n); end
    run_range(0, 2, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL over_err: got %0h expected 1", err); end
    checks++; if ({in_ready, busy, done, cpu_rst_n} !== 4'b0000) begin errors++; $display("FAIL over_outputs: got %04b expected 0000", {in_ready, busy, done, cpu_rst_n}); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL over_writes: got %0d expected 0", wr_n); end
    words = {16'h0BAD};
    build(16'd1);
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, err, cpu_rst_n} !== 3'b101) begin errors++; $display("FAIL over_recover: got %03b expected 101", {done, err, cpu_rst_n}); end
    checks++; if (shadow[0] !== 16'h0BAD) begin errors++; $display("FAIL over_recover_data: got %0h expected 0bad", shadow[0]); end
  endtask

  task automatic test_full_capacity();
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(16'h0100 + 16'(i));
    build(16'd16);
    clear_log();
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL full_done: got %02b expected 10", {done, err}); end
    checks++; if (wr_n !== 16) begin errors++; $display("FAIL full_writes: got %0d expected 16", wr_n); end
    if (wr_n == 16) begin
      checks++; if (wr_addr[15] !== 4'hF) begin errors++; $display("FAIL full_last_addr: got %0h expected f", wr_addr[15]); end
      checks++; if (wr_data[15] !== 16'h010F) begin errors++; $display("FAIL full_last_data: got %0h expected 010f", wr_data[15]); end
    end
  endtask

  task automatic test_start_while_busy();
    words = {16'h2222, 16'h3333};
    build(16'd2);
    clear_log();
    do_start();
    run_range(0, 3, 0);
    do_start();
    run_range(3, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, word_count} !== {1'b1, 16'd2}) begin errors++; $display("FAIL busy_start_done: got %0h expected 10002", {done, word_count}); end
    checks++; if (wr_n !== 2) begin errors++; $display("FAIL busy_start_writes: got %0d expected 2", wr_n); end
    checks++; if (shadow[1] !== 16'h3333) begin errors++; $display("FAIL busy_start_data: got %0h expected 3333", shadow[1]); end
  endtask

  task automatic test_reset_mid_load();
    words = {16'h1234, 16'hABCD, 16'hFFFF};
    build(16'd3);
    clear_log();
    do_start();
    run_range(0, 3, 0);
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({in_ready, imem_we, cpu_rst_n, busy, done, err} !== 6'd0) begin errors++; $display("FAIL midrst_flags: got %06b expected 000000", {in_ready, imem_we, cpu_rst_n, busy, done, err}); end
    checks++; if ({imem_addr, imem_wdata, word_count} !== 36'd0) begin errors++; $display("FAIL midrst_regs: got %0h expected 0", {imem_addr, imem_wdata, word_count}); end
    @(negedge CLK) RST_N = 1'b1;
    clear_log();
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, cpu_rst_n, wr_n} !== {2'b11, 32'd3}) begin errors++; $display("FAIL midrst_reload: done/cpu_rst_n %0b%0b writes %0d expected 11 3", done, cpu_rst_n, wr_n); end
    checks++; if (shadow[2] !== 16'hFFFF) begin errors++; $display("FAIL midrst_data: got %0h expected ffff", shadow[2]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    clear_log();
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, err, cpu_rst_n} !== 3'b101) begin errors++; $display("FAIL csum_good: got %03b expected 101", {done, err, cpu_rst_n}); end
    q = {8'h00, 8'h01, 8'h55, 8'h55, 8'h01};
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if (shadow[0] !== 16'h5555) begin errors++; $display("FAIL csum_preload: got %0h expected 5555", shadow[0]); end
    q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    do_start();
    run_range(0, q.size(), 0);
    @(negedge CLK);
    checks++; if ({done, err, cpu_rst_n} !== 3'b010) begin errors++; $display("FAIL csum_bad: got %03b expected 010", {done, err, cpu_rst_n}); end
    checks++; if (shadow[0] !== 16'h1234) begin errors++; $display("FAIL csum_bad_data: got %0h expected 1234", shadow[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(5, "stall");
    test_zero_len();
    test_oversize();
    test_full_capacity();
    test_start_while_busy();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

endmodule
